opamp_cal_ctrl: RTL

//  Digital sequencer for the folded-cascode op-amp macro. On request it enables the bias

---
 rtl/opamp_cal_ctrl.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/opamp_cal_ctrl.sv
// ----------------------------------------------------------------------------
// opamp_cal_ctrl
//
// Digital calibration sequencer for the folded-cascode op-amp macro.
// When a calibration is requested it enables the bias current and waits for
// the bias to settle. It then shorts the amplifier inputs and runs a
// successive-approximation search on the offset-trim code. Each trial is
// judged by a comparator on the amplifier output.
//
// Ports
//   wb_clk_i    in   1       single clock
//   wb_rst_i    in   1       synchronous reset, active-high
//   start_i     in   1       calibration request (only honoured in IDLE)
//   abort_i     in   1       abort calibration, any state
//   cmp_i       in   1       asynchronous comparator, 1 = offset positive
//   ib_en_o     out  1       bias current enable
//   short_en_o  out  1       IN_P/IN_M short switch enable
//   trim_o      out  TRIM_W  offset-trim code to the macro
//   busy_o      out  1       sequencer active (any state but IDLE)
//   done_o      out  1       one-cycle completion pulse
//   cal_valid_o out  1       trim_o holds a completed calibration result
// ----------------------------------------------------------------------------
module opamp_cal_ctrl #(
  parameter int TRIM_W     = 6,
  parameter int BIAS_WAIT  = 64,
  parameter int SETTLE_CYC = 16,
  parameter int CNT_W      = 8
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic              cmp_i,
  output logic              ib_en_o,
  output logic              short_en_o,
  output logic [TRIM_W-1:0] trim_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              cal_valid_o
);

  localparam int K_W = (TRIM_W > 1) ? $clog2(TRIM_W) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_BIAS   = 3'd1;
  localparam logic [2:0] ST_TRIAL  = 3'd2;
  localparam logic [2:0] ST_DECIDE = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  localparam logic [TRIM_W-1:0] TRIM_MID    = TRIM_W'(1'b1) << (TRIM_W - 1);
  localparam logic [TRIM_W-1:0] TRIM_ZERO   = '0;
  localparam logic [CNT_W-1:0]  CNT_ZERO    = '0;
  localparam logic [CNT_W-1:0]  CNT_ONE     = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0]  BIAS_LAST   = CNT_W'(BIAS_WAIT - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [K_W-1:0]    K_ZERO      = '0;
  localparam logic [K_W-1:0]    K_ONE       = K_W'(1'b1);
  localparam logic [K_W-1:0]    K_MSB       = K_W'(TRIM_W - 1);

  logic [2:0]        state_r;
  logic [2:0]        state_nxt_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [CNT_W-1:0]  cnt_nxt_s;
  logic [K_W-1:0]    bit_idx_r;
  logic [K_W-1:0]    bit_idx_nxt_s;
  logic [TRIM_W-1:0] trim_r;
  logic [TRIM_W-1:0] trim_nxt_s;
  logic              ib_en_r;
  logic              ib_en_nxt_s;
  logic              short_en_r;
  logic              short_en_nxt_s;
  logic              busy_r;
  logic              busy_nxt_s;
  logic              done_r;
  logic              done_nxt_s;
  logic              cal_valid_r;
  logic              cal_valid_nxt_s;
  logic              cmp_meta_r;
  logic              cmp_sync_r;
  logic              cmp_s;

  assign cmp_s = cmp_sync_r;

  // Two-flop synchronizer for the asynchronous comparator output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      cmp_meta_r <= 1'b0;
      cmp_sync_r <= 1'b0;
    end else begin
      cmp_meta_r <= cmp_i;
      cmp_sync_r <= cmp_meta_r;
    end
  end

  // Sequencer next-state and next-output logic; abort overrides everything.
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    bit_idx_nxt_s   = bit_idx_r;
    trim_nxt_s      = trim_r;
    ib_en_nxt_s     = ib_en_r;
    short_en_nxt_s  = short_en_r;
    busy_nxt_s      = busy_r;
    done_nxt_s      = 1'b0;
    cal_valid_nxt_s = cal_valid_r;

    if (abort_i) begin
      state_nxt_s     = ST_IDLE;
      cnt_nxt_s       = CNT_ZERO;
      bit_idx_nxt_s   = K_MSB;
      trim_nxt_s      = TRIM_MID;
      ib_en_nxt_s     = 1'b0;
      short_en_nxt_s  = 1'b0;
      busy_nxt_s      = 1'b0;
      cal_valid_nxt_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start_i) begin
            // A new run always starts from an all-zero code; any previous
            // result is discarded.
            state_nxt_s     = ST_BIAS;
            cnt_nxt_s       = CNT_ZERO;
            bit_idx_nxt_s   = K_MSB;
            trim_nxt_s      = TRIM_ZERO;
            ib_en_nxt_s     = 1'b1;
            short_en_nxt_s  = 1'b1;
            busy_nxt_s      = 1'b1;
            cal_valid_nxt_s = 1'b0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end

        ST_BIAS: begin
          if (cnt_r == BIAS_LAST) begin
            state_nxt_s            = ST_TRIAL;
            cnt_nxt_s              = CNT_ZERO;
            trim_nxt_s[bit_idx_r]  = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end

        ST_TRIAL: begin
          // The trial code is held long enough for the amplifier to settle
          // and for the comparator to pass through the synchronizer.
          if (cnt_r == SETTLE_LAST) begin
            state_nxt_s = ST_DECIDE;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end

        ST_DECIDE: begin
          // A positive offset means the trial bit overshoots, so it is dropped.
          trim_nxt_s[bit_idx_r] = ~cmp_s;
          if (bit_idx_r == K_ZERO) begin
            state_nxt_s = ST_DONE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s                     = ST_TRIAL;
            bit_idx_nxt_s                   = bit_idx_r - K_ONE;
            trim_nxt_s[bit_idx_r - K_ONE]   = 1'b1;
            cnt_nxt_s                       = CNT_ZERO;
          end
        end

        ST_DONE: begin
          // Bias stays on so the trimmed amplifier is immediately usable.
          state_nxt_s     = ST_IDLE;
          cal_valid_nxt_s = 1'b1;
          short_en_nxt_s  = 1'b0;
          busy_nxt_s      = 1'b0;
          cnt_nxt_s       = CNT_ZERO;
          bit_idx_nxt_s   = K_MSB;
        end

        default: begin
          state_nxt_s     = ST_IDLE;
          cnt_nxt_s       = CNT_ZERO;
          bit_idx_nxt_s   = K_MSB;
          trim_nxt_s      = TRIM_MID;
          ib_en_nxt_s     = 1'b0;
          short_en_nxt_s  = 1'b0;
          busy_nxt_s      = 1'b0;
          cal_valid_nxt_s = 1'b0;
        end
      endcase
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      bit_idx_r   <= K_MSB;
      trim_r      <= TRIM_MID;
      ib_en_r     <= 1'b0;
      short_en_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      cal_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      bit_idx_r   <= bit_idx_nxt_s;
      trim_r      <= trim_nxt_s;
      ib_en_r     <= ib_en_nxt_s;
      short_en_r  <= short_en_nxt_s;
      busy_r      <= busy_nxt_s;
      done_r      <= done_nxt_s;
      cal_valid_r <= cal_valid_nxt_s;
    end
  end

  assign ib_en_o     = ib_en_r;
  assign short_en_o  = short_en_r;
  assign trim_o      = trim_r;
  assign busy_o      = busy_r;
  assign done_o      = done_r;
  assign cal_valid_o = cal_valid_r;

endmodule
